// File: rtl/mul_client.sv
// mul_client: request-side initiator for the buffered multiplier.
// Queues operand pairs in a small FIFO and issues them one at a time on the
// multiplier's valid-only input port. It then waits for the result, or times
// out, and hands the result back with its latency on a valid/ready port.
// Optional feature: define MUL_CLIENT_CONST_TIME_EN for constant-time
// responses. The response then always appears MAX_LAT+1 cycles after issue
// and rsp_lat always reports MAX_LAT.
module mul_client #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int MAX_LAT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic                 mul_in_valid,
    output logic [WIDTH-1:0]     mul_in_a,
    output logic [WIDTH-1:0]     mul_in_b,
    input  logic                 mul_out_valid,
    input  logic [2*WIDTH-1:0]   mul_out_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic [3:0]           rsp_lat,
    output logic                 rsp_timeout,
    output logic                 busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(1'b0);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(1'b0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [4:0]    MAX_LAT_C = 5'(MAX_LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t               state_r, state_n;
    logic [WIDTH-1:0]     mem_a_r [DEPTH];
    logic [WIDTH-1:0]     mem_b_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [AW:0]          count_r;
    logic                 full_s, push_s, pop_s;
    logic [3:0]           cnt_r, cnt_sat_s, lat_val_s;
    logic [4:0]           cnt_inc_s;
    logic                 in_wait_s, last_s, cap_s, tmo_s, captured_r;
    logic                 mul_in_valid_r, rsp_valid_r, rsp_timeout_r;
    logic [WIDTH-1:0]     mul_in_a_r, mul_in_b_r;
    logic [2*WIDTH-1:0]   rsp_result_r;
    logic [3:0]           rsp_lat_r;

    // A full FIFO refuses a push even when the FSM pops in the same cycle.
    assign full_s = (count_r == DEPTH_C);
    assign push_s = req_valid && !full_s;
    assign pop_s  = (state_r == ST_ISSUE);

    // Latency counter arithmetic and the WAIT-state capture/timeout decisions
    always_comb begin
        cnt_inc_s = {1'b0, cnt_r} + 5'd1;
        in_wait_s = (state_r == ST_WAIT);
        last_s    = (cnt_inc_s == MAX_LAT_C);
        // A capture on the last cycle wins over the timeout.
        cap_s     = in_wait_s && mul_out_valid && !captured_r && (cnt_inc_s <= MAX_LAT_C);
        tmo_s     = in_wait_s && last_s && !mul_out_valid && !captured_r;
        if (cnt_inc_s >= MAX_LAT_C) begin
            cnt_sat_s = MAX_LAT_C[3:0];
        end else begin
            cnt_sat_s = cnt_inc_s[3:0];
        end
`ifdef MUL_CLIENT_CONST_TIME_EN
        lat_val_s = MAX_LAT_C[3:0];
`else
        lat_val_s = cnt_inc_s[3:0];
`endif
    end

    // FIFO storage; stale entries are harmless because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r] <= req_a;
            mem_b_r[wr_ptr_r] <= req_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic: one outstanding operation at a time
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    state_n = ST_ISSUE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: state_n = ST_WAIT;
            ST_WAIT: begin
`ifdef MUL_CLIENT_CONST_TIME_EN
                // The response time does not depend on when the result arrived.
                if (last_s) begin
`else
                if (cap_s || tmo_s) begin
`endif
                    state_n = ST_HOLD;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_HOLD;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Issue, latency measurement and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_in_valid_r <= 1'b0;
            mul_in_a_r     <= {WIDTH{1'b0}};
            mul_in_b_r     <= {WIDTH{1'b0}};
            cnt_r          <= 4'd0;
            captured_r     <= 1'b0;
            rsp_valid_r    <= 1'b0;
            rsp_result_r   <= {(2*WIDTH){1'b0}};
            rsp_lat_r      <= 4'd0;
            rsp_timeout_r  <= 1'b0;
        end else begin
            mul_in_valid_r <= (state_r == ST_ISSUE);
            if (state_r == ST_ISSUE) begin
                mul_in_a_r <= mem_a_r[rd_ptr_r];
                mul_in_b_r <= mem_b_r[rd_ptr_r];
                cnt_r      <= 4'd0;
                captured_r <= 1'b0;
            end else if (in_wait_s) begin
                cnt_r <= cnt_sat_s;
            end
            if (cap_s) begin
                rsp_result_r  <= mul_out_result;
                rsp_lat_r     <= lat_val_s;
                rsp_timeout_r <= 1'b0;
                captured_r    <= 1'b1;
            end else if (tmo_s) begin
                rsp_result_r  <= {(2*WIDTH){1'b0}};
                rsp_lat_r     <= MAX_LAT_C[3:0];
                rsp_timeout_r <= 1'b1;
            end
            if (in_wait_s && (state_n == ST_HOLD)) begin
                rsp_valid_r <= 1'b1;
            end else if ((state_r == ST_HOLD) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign req_ready    = !full_s;
    assign busy         = (state_r != ST_IDLE) || (count_r != CNT_ZERO);
    assign mul_in_valid = mul_in_valid_r;
    assign mul_in_a     = mul_in_a_r;
    assign mul_in_b     = mul_in_b_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_result   = rsp_result_r;
    assign rsp_lat      = rsp_lat_r;
    assign rsp_timeout  = rsp_timeout_r;

endmodule
